bcd_convert_seq: RTL

- Time-shared, sequential double-dabble converter for the clock's six time/date fields.
- One add-3/shift iteration runs per cycle on a single engine, scheduled field by field: ss, mm, hh, dd, mo, yyyy.
- Replaces six parallel combinational converters between the calendar counters and the display mux.
- Outputs update atomically once per conversion, so the display never shows a mixed old/new set.

---
 rtl/bcd_convert_seq.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/bcd_convert_seq.sv
// Time-shared double-dabble converter for the six clock/date fields; one add-3/shift step per cycle.
// Results collect in shadow registers and reach the outputs together, one cycle after the DONE state.
module bcd_convert_seq #(
  parameter int YEAR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [5:0]        sec_bin,
  input  logic [5:0]        min_bin,
  input  logic [4:0]        hour_bin,
  input  logic [4:0]        day_bin,
  input  logic [3:0]        month_bin,
  input  logic [YEAR_W-1:0] year_bin,
  output logic [7:0]        bcd_ss,
  output logic [7:0]        bcd_mm,
  output logic [7:0]        bcd_hh,
  output logic [7:0]        bcd_dd,
  output logic [7:0]        bcd_mo,
  output logic [15:0]       bcd_yyyy,
  output logic              busy,
  output logic              done
);

  localparam int BW = (YEAR_W > 12) ? YEAR_W : 12;
  localparam int EW = 16 + BW;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, DONE} state_t;

  state_t            state;
  logic [2:0]        fidx;
  logic [3:0]        cnt;
  logic              pending;
  logic [EW-1:0]     eng;
  logic [EW-1:0]     eng_nxt;
  logic [15:0]       bcd_adj;
  logic [BW-1:0]     sel_val;
  logic [BW-1:0]     load_bin;
  logic [3:0]        sel_w;
  logic              take_snap;

  logic [5:0]        snap_ss, snap_mm;
  logic [4:0]        snap_hh, snap_dd;
  logic [3:0]        snap_mo;
  logic [YEAR_W-1:0] snap_yy;
  logic [7:0]        sh_ss, sh_mm, sh_hh, sh_dd, sh_mo;
  logic [15:0]       sh_yy;

  always_comb begin
    sel_val = '0;
    sel_w   = 4'd6;
    case (fidx)
      3'd0:    begin sel_val = BW'(snap_ss); sel_w = 4'd6; end
      3'd1:    begin sel_val = BW'(snap_mm); sel_w = 4'd6; end
      3'd2:    begin sel_val = BW'(snap_hh); sel_w = 4'd5; end
      3'd3:    begin sel_val = BW'(snap_dd); sel_w = 4'd5; end
      3'd4:    begin sel_val = BW'(snap_mo); sel_w = 4'd4; end
      default: begin sel_val = BW'(snap_yy); sel_w = 4'(YEAR_W); end
    endcase
    // left-justify so the field MSB leads the shift into the BCD part
    load_bin = sel_val << (4'(BW) - sel_w);
  end

  always_comb begin
    bcd_adj = '0;
    for (int n = 0; n < 4; n++) begin
      bcd_adj[4*n +: 4] = (eng[BW+4*n +: 4] >= 4'd5) ? eng[BW+4*n +: 4] + 4'd3
                                                     : eng[BW+4*n +: 4];
    end
    eng_nxt = {bcd_adj, eng[BW-1:0]} << 1;
  end

  assign take_snap = ((state == IDLE) && start) || ((state == DONE) && (pending || start));

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_ss <= '0;
      snap_mm <= '0;
      snap_hh <= '0;
      snap_dd <= '0;
      snap_mo <= '0;
      snap_yy <= '0;
    end else if (take_snap) begin
      snap_ss <= sec_bin;
      snap_mm <= min_bin;
      snap_hh <= hour_bin;
      snap_dd <= day_bin;
      snap_mo <= month_bin;
      snap_yy <= year_bin;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fidx     <= '0;
      cnt      <= '0;
      pending  <= 1'b0;
      eng      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sh_ss    <= '0;
      sh_mm    <= '0;
      sh_hh    <= '0;
      sh_dd    <= '0;
      sh_mo    <= '0;
      sh_yy    <= '0;
      bcd_ss   <= '0;
      bcd_mm   <= '0;
      bcd_hh   <= '0;
      bcd_dd   <= '0;
      bcd_mo   <= '0;
      bcd_yyyy <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= start;
          fidx <= '0;
          if (start) state <= LOAD;
        end
        LOAD: begin
          busy    <= 1'b1;
          pending <= pending | start;
          eng     <= {16'd0, load_bin};
          cnt     <= sel_w;
          state   <= SHIFT;
        end
        SHIFT: begin
          busy    <= 1'b1;
          pending <= pending | start;
          eng     <= eng_nxt;
          cnt     <= cnt - 4'd1;
          if (cnt == 4'd1) state <= STORE;
        end
        STORE: begin
          pending <= pending | start;
          case (fidx)
            3'd0:    sh_ss <= eng[BW +: 8];
            3'd1:    sh_mm <= eng[BW +: 8];
            3'd2:    sh_hh <= eng[BW +: 8];
            3'd3:    sh_dd <= eng[BW +: 8];
            3'd4:    sh_mo <= eng[BW +: 8];
            default: sh_yy <= eng[BW +: 16];
          endcase
          if (fidx == 3'd5) begin
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            busy  <= 1'b1;
            fidx  <= fidx + 3'd1;
            state <= LOAD;
          end
        end
        DONE: begin
          bcd_ss   <= sh_ss;
          bcd_mm   <= sh_mm;
          bcd_hh   <= sh_hh;
          bcd_dd   <= sh_dd;
          bcd_mo   <= sh_mo;
          bcd_yyyy <= sh_yy;
          done     <= 1'b1;
          pending  <= 1'b0;
          fidx     <= '0;
          // a request seen during the run (or right now) restarts without an IDLE gap
          busy     <= pending | start;
          state    <= (pending || start) ? LOAD : IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
